// File: rtl/motor_control_pkg.sv
// motor_control_pkg: types shared between the current control loop and the PWM stage.
package motor_control_pkg;

    localparam int PWM_COUNT_WIDTH = 12;

    typedef logic [PWM_COUNT_WIDTH-1:0] duty_t;

    typedef enum logic [2:0] {
        SAFE    = 3'd0,
        LOW_ON  = 3'd1,
        DEAD_LH = 3'd2,
        HIGH_ON = 3'd3,
        DEAD_HL = 3'd4
    } pwm_state_t;

endpackage

// File: rtl/pwm_deadtime_fsm.sv
// pwm_deadtime_fsm: complementary gate sequencer with dead time; MOTOR_PWM_DEADTIME_EN enables
// the dead states, otherwise gates follow the registered compare directly.
module pwm_deadtime_fsm
    import motor_control_pkg::*;
`ifdef MOTOR_PWM_DEADTIME_EN
#(
    parameter int DEAD_CYCLES = 16
)
`endif
(
    input  logic PwmClock,
    input  logic PwmReset_n,
    input  logic RawHigh,
    input  logic Running,
    input  logic Fault,
    output logic HighSideGate,
    output logic LowSideGate
);

    pwm_state_t state;
    pwm_state_t nextState;
    logic       deadDone;

`ifdef MOTOR_PWM_DEADTIME_EN
    localparam pwm_state_t ToHigh = DEAD_LH;
    localparam pwm_state_t ToLow  = DEAD_HL;
    logic [7:0] deadCount;
    assign deadDone = deadCount == 8'(DEAD_CYCLES - 1);
    // Restarts on every state change so each dead window is measured from its own entry.
    always_ff @(posedge PwmClock) begin
        if (!PwmReset_n)
            deadCount <= '0;
        else
            deadCount <= (nextState != state) ? '0 : deadCount + 8'd1;
    end
`else
    localparam pwm_state_t ToHigh = HIGH_ON;
    localparam pwm_state_t ToLow  = LOW_ON;
    assign deadDone = 1'b1;
`endif

    always_comb begin
        nextState = state;
        if (Fault || !Running)
            nextState = SAFE;
        else
            case (state)
                SAFE:    nextState = RawHigh ? ToHigh : ToLow;
                LOW_ON:  nextState = RawHigh ? ToHigh : LOW_ON;
                DEAD_LH: nextState = !RawHigh ? LOW_ON : deadDone ? HIGH_ON : DEAD_LH;
                HIGH_ON: nextState = RawHigh ? HIGH_ON : ToLow;
                DEAD_HL: nextState = RawHigh ? HIGH_ON : deadDone ? LOW_ON : DEAD_HL;
                default: nextState = SAFE;
            endcase
    end

    always_ff @(posedge PwmClock) begin
        if (!PwmReset_n) begin
            state        <= SAFE;
            HighSideGate <= 1'b0;
            LowSideGate  <= 1'b0;
        end else begin
            state        <= nextState;
            HighSideGate <= nextState == HIGH_ON;
            LowSideGate  <= nextState == LOW_ON;
        end
    end

endmodule

// File: rtl/motor_pwm_generator.sv
// motor_pwm_generator: edge-aligned half-bridge PWM with double-buffered duty, fault latch and
// period strobe; dead-time insertion is built only when MOTOR_PWM_DEADTIME_EN is defined.
module motor_pwm_generator
    import motor_control_pkg::*;
#(
    parameter int COUNT_WIDTH = PWM_COUNT_WIDTH,
    parameter int DEAD_CYCLES = 16
)(
    input  logic                   PwmClock,
    input  logic                   PwmReset_n,
    input  logic [COUNT_WIDTH-1:0] MotorSignal,
    input  logic                   PwmEnable,
    input  logic                   Fault,
    input  logic                   FaultClear,
    output logic                   HighSideGate,
    output logic                   LowSideGate,
    output logic                   PeriodStart,
    output logic                   FaultLatched,
    output logic [COUNT_WIDTH-1:0] PwmCount
);

    // A dead time outside 1..255 cannot be honoured, so such a build never drives the bridge.
    localparam bit DeadCyclesValid = (DEAD_CYCLES >= 1) && (DEAD_CYCLES <= 255);

    logic                   running;
    logic                   rawHigh;
    logic [COUNT_WIDTH-1:0] dutyShadow;

    assign running     = PwmReset_n && PwmEnable && !FaultLatched && DeadCyclesValid;
    assign rawHigh     = PwmCount < dutyShadow;
    assign PeriodStart = running && (PwmCount == '0);

    always_ff @(posedge PwmClock) begin
        if (!PwmReset_n) begin
            PwmCount     <= '0;
            dutyShadow   <= '0;
            FaultLatched <= 1'b0;
        end else begin
            FaultLatched <= Fault || (FaultLatched && !FaultClear);
            PwmCount     <= running ? PwmCount + COUNT_WIDTH'(1) : '0;
            if (!running || PwmCount == '1)
                dutyShadow <= MotorSignal;
        end
    end

    pwm_deadtime_fsm
`ifdef MOTOR_PWM_DEADTIME_EN
    #(.DEAD_CYCLES(DEAD_CYCLES))
`endif
    u_fsm (
        .PwmClock    (PwmClock),
        .PwmReset_n  (PwmReset_n),
        .RawHigh     (rawHigh),
        .Running     (running),
        .Fault       (Fault),
        .HighSideGate(HighSideGate),
        .LowSideGate (LowSideGate)
    );

endmodule

// File: tb/tb_motor_pwm_generator.sv
// tb_motor_pwm_generator: directed checks of period timing, duty buffering, extremes, fault and disable.
module tb_motor_pwm_generator;

`ifdef MOTOR_PWM_DEADTIME_EN
    localparam int DT = 16;
`else
    localparam int DT = 0;
`endif

    logic        PwmClock = 1'b0;
    logic        PwmReset_n;
    logic [11:0] MotorSignal;
    logic        PwmEnable;
    logic        Fault;
    logic        FaultClear;
    logic        HighSideGate;
    logic        LowSideGate;
    logic        PeriodStart;
    logic        FaultLatched;
    logic [11:0] PwmCount;

    int checks = 0;
    int failures = 0;
    int hi, lo, off, both, ps, j;

    always #5 PwmClock = ~PwmClock;

    motor_pwm_generator #(.COUNT_WIDTH(12), .DEAD_CYCLES(16)) dut (
        .PwmClock    (PwmClock),
        .PwmReset_n  (PwmReset_n),
        .MotorSignal (MotorSignal),
        .PwmEnable   (PwmEnable),
        .Fault       (Fault),
        .FaultClear  (FaultClear),
        .HighSideGate(HighSideGate),
        .LowSideGate (LowSideGate),
        .PeriodStart (PeriodStart),
        .FaultLatched(FaultLatched),
        .PwmCount    (PwmCount)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic waitPeriodStart();
        int n = 0;
        while (PeriodStart !== 1'b1 && n < 5000) begin
            @(negedge PwmClock);
            n++;
        end
        chk("wait_period_start", int'(PeriodStart), 1);
    endtask

    task automatic waitCount(input int c);
        int n = 0;
        while (int'(PwmCount) != c && n < 5000) begin
            @(negedge PwmClock);
            n++;
        end
        chk("wait_count", int'(PwmCount), c);
    endtask

    // Entered at the negedge of a count-0 cycle; leaves at the next count-0 cycle.
    task automatic measure(input int changeAt, input int newDuty);
        hi = 0; lo = 0; off = 0; both = 0; ps = 0;
        for (int i = 0; i < 4096; i++) begin
            hi += int'(HighSideGate);
            lo += int'(LowSideGate);
            if (HighSideGate && LowSideGate) both++;
            if (!HighSideGate && !LowSideGate) off++;
            ps += int'(PeriodStart);
            if (i == changeAt) MotorSignal = 12'(newDuty);
            @(negedge PwmClock);
        end
    endtask

    initial begin
        PwmReset_n = 1'b0; PwmEnable = 1'b0; Fault = 1'b0; FaultClear = 1'b0; MotorSignal = 12'd1024;
        repeat (3) @(negedge PwmClock);
        PwmReset_n = 1'b1;
        @(negedge PwmClock);
        chk("rst_high", int'(HighSideGate), 0);
        chk("rst_low", int'(LowSideGate), 0);
        chk("rst_ps", int'(PeriodStart), 0);
        chk("rst_fault", int'(FaultLatched), 0);
        chk("rst_count", int'(PwmCount), 0);

        PwmEnable = 1'b1;
        #1;
        chk("enable_first_ps", int'(PeriodStart), 1);
        @(negedge PwmClock);
        waitPeriodStart();

        measure(-1, 0);
        chk("steady_high", hi, 1024 - DT);
        chk("steady_low", lo, 3072 - DT);
        chk("steady_off", off, 2 * DT);
        chk("steady_both", both, 0);
        chk("steady_ps_count", ps, 1);
        chk("period_ps", int'(PeriodStart), 1);
        chk("period_count", int'(PwmCount), 0);

        measure(500, 2048);
        chk("midchange_cur_high", hi, 1024 - DT);
        measure(0, 0);
        chk("midchange_next_high", hi, 2048 - DT);
        chk("midchange_next_low", lo, 2048 - DT);

        measure(0, 4095);
        chk("duty0_high", hi, 0);
        chk("duty0_low", lo, 4096);
        measure(-1, 0);
        chk("trans_both", both, 0);
        measure(0, 3072);
        chk("duty4095_high", hi, 4095);
        chk("duty4095_low", lo, (DT > 0) ? 0 : 1);
        chk("duty4095_off", off, (DT > 0) ? 1 : 0);

        waitCount(2000);
        chk("fault_pre_high", int'(HighSideGate), 1);
        Fault = 1'b1; MotorSignal = 12'd1024;
        @(negedge PwmClock);
        Fault = 1'b0;
        chk("fault_high", int'(HighSideGate), 0);
        chk("fault_low", int'(LowSideGate), 0);
        chk("fault_latched", int'(FaultLatched), 1);
        @(negedge PwmClock);
        chk("fault_count_held", int'(PwmCount), 0);
        chk("fault_no_ps", int'(PeriodStart), 0);
        Fault = 1'b1; FaultClear = 1'b1;
        @(negedge PwmClock);
        chk("fault_wins", int'(FaultLatched), 1);
        Fault = 1'b0;
        @(negedge PwmClock);
        FaultClear = 1'b0;
        chk("clear_latched", int'(FaultLatched), 0);
        chk("clear_count", int'(PwmCount), 0);
        chk("clear_ps", int'(PeriodStart), 1);
        j = 0;
        while (!HighSideGate && j < 100) begin
            @(negedge PwmClock);
            j++;
        end
        chk("clear_high_latency", j, 1 + DT);

        waitCount(300);
        PwmEnable = 1'b0;
        @(negedge PwmClock);
        chk("disable_high", int'(HighSideGate), 0);
        chk("disable_low", int'(LowSideGate), 0);
        chk("disable_count", int'(PwmCount), 0);
        chk("disable_ps", int'(PeriodStart), 0);
        repeat (3) @(negedge PwmClock);
        PwmEnable = 1'b1;
        #1;
        chk("reenable_ps", int'(PeriodStart), 1);
        @(negedge PwmClock);
        waitPeriodStart();

        measure(0, int'($urandom_range(0, 4095)));
        chk("rand_first_both", both, 0);
        for (int k = 0; k < 4; k++) begin
            measure(0, int'($urandom_range(0, 4095)));
            chk("rand_both", both, 0);
`ifndef MOTOR_PWM_DEADTIME_EN
            chk("rand_complement", off, 0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motor_pwm_generator.md
# motor_pwm_generator

Converts the 12-bit `MotorSignal` duty word produced by the current control loop into a complementary high-side/low-side gate pair for one motor half-bridge. The block is the consumer end of the `MotorSignal` interface. It runs a free-running edge-aligned period counter, double-buffers the duty word at the period boundary, and inserts dead time between gates. It also latches external faults into a safe all-off state and emits a period-start strobe for ADC sampling.

## Interface
- `COUNT_WIDTH`, 12: counter and duty width; period = 2^COUNT_WIDTH cycles.
- `DEAD_CYCLES`, 16: both-gates-off cycles inserted before either gate turns on; range 1..255.
- `PwmClock` in 1: sole clock; all state changes on its rising edge.
- `PwmReset_n` in 1: reset, synchronous, active-low.
- `MotorSignal` in COUNT_WIDTH: requested duty, unsigned, 0 = always low-side.
- `PwmEnable` in 1: level; 0 forces safe state and holds the counter at 0.
- `Fault` in 1: external overcurrent or driver fault, level, synchronous.
- `FaultClear` in 1: single-cycle request to leave the latched fault.
- `HighSideGate` out 1: high-side FET drive, registered.
- `LowSideGate` out 1: low-side FET drive, registered.
- `PeriodStart` out 1: one-cycle strobe while the counter is 0 and running.
- `FaultLatched` out 1: sticky fault flag.
- `PwmCount` out COUNT_WIDTH: current counter value, for ADC trigger alignment.

## Operation
- **Reset:** all outputs are 0. Counter = 0, duty shadow = 0, FSM = SAFE, FaultLatched = 0.
- **Running condition:** `PwmEnable`=1 and `FaultLatched`=0.
- **Counter:** increments by 1 per cycle while running and wraps from max to 0. When not running it is held at 0.
- **Duty shadow:** loads `MotorSignal` on the cycle where counter = max, or on any cycle while not running. The new duty therefore takes effect from count 0. Mid-period changes of `MotorSignal` have no effect on the current period.
- **Raw compare:** `RawHigh = (count < shadow)`, unsigned. Duty 0 gives RawHigh never asserted. Duty max gives RawHigh low only at count = max.
- **Gate FSM states:** SAFE, LOW_ON, DEAD_LH, HIGH_ON, DEAD_HL.
  - SAFE: both gates off. Go to LOW_ON when running and RawHigh=0; go to DEAD_LH when running and RawHigh=1.
  - LOW_ON: low gate on. RawHigh=1 → DEAD_LH.
  - DEAD_LH: both gates off; the dead counter counts to DEAD_CYCLES, then → HIGH_ON. If RawHigh drops first → LOW_ON immediately.
  - HIGH_ON: high gate on. RawHigh=0 → DEAD_HL.
  - DEAD_HL: mirror of DEAD_LH. Completes → LOW_ON; RawHigh rises first → HIGH_ON.
  - The dead counter clears on every state entry.
- **Invariant:** `HighSideGate` and `LowSideGate` are never both 1 in any cycle.
- **Fault:** `Fault`=1 on any edge sets `FaultLatched` and sends the FSM to SAFE on that same edge.
  - `FaultClear`=1 with `Fault`=0 clears the latch.
  - If `Fault` and `FaultClear` are asserted together, `Fault` wins.
  - After clear, the counter restarts from 0 and the FSM leaves SAFE as above.
- **Disable:** `PwmEnable`=0 sends the FSM to SAFE on the next edge and zeroes the counter. `FaultLatched` is unaffected.

## Timing
- **Gate latency:** a RawHigh edge produced by counter value c at cycle n is seen by the FSM at edge n+1.
  - The gate turning off changes at n+1.
  - The opposite gate turns on at n+1+DEAD_CYCLES.
- **Pulse widths:** high-side on-time = duty − DEAD_CYCLES per period. Low-side on-time = 2^W − duty − DEAD_CYCLES. A raw pulse of DEAD_CYCLES or shorter produces no gate pulse.
- **Fault response:** gates reach 0 one edge after `Fault` is sampled high.
- **`PeriodStart`:** asserts for one cycle every 2^W cycles while running. The first assertion occurs on the first running cycle after enable or fault clear.

## Configuration
- Macro `MOTOR_PWM_DEADTIME_EN`.
- **Defined:** dead-time insertion as described.
- **Undefined:**
  - DEAD_LH and DEAD_HL are never entered; `DEAD_CYCLES` is ignored.
  - While running, HighSideGate = registered RawHigh and LowSideGate = registered ~RawHigh.
  - SAFE behaviour is unchanged.
  - Use this only with gate drivers that have hardware dead time.

## Structure
- **Shared package `motor_control_pkg`:** `pwm_state_t` enum, default `COUNT_WIDTH`, and duty word typedef `duty_t`. `duty_t` is shared with the current control loop.
- **Sub-module `pwm_deadtime_fsm`:** inputs RawHigh, Running, and Fault; outputs both gates; contains the FSM and dead counter.
- **Top level:** contains the counter, duty shadow, fault latch, and strobe.

## Test plan
- **Steady duty:** reset, enable, `MotorSignal`=1024, DEAD=16 → per 4096-cycle period: high pulse 1008 cycles, low pulse 3056 cycles, two 16-cycle both-off gaps, `PeriodStart` every 4096 cycles.
- **Mid-period change:** `MotorSignal` 1024→2048 at count 500 → current period high pulse 1008; next period high pulse 2032.
- **Extreme duties:** duty 0 → low-side constantly on, high-side never. Duty 4095 → high-side drops for exactly 1 cycle per period, low-side never asserts.
- **Fault handling:** `Fault` pulse at count 2000 with high-side on → both gates 0 at the next edge and `FaultLatched`=1. `FaultClear` with `Fault`=1 → still latched. Clear with `Fault`=0 → counter restarts at 0 and high-side rises 17 edges later (duty 1024).
- **Disable:** `PwmEnable`=0 mid-period → both gates 0 and `PwmCount`=0 at the next edge. Re-enable → `PeriodStart` on the first running cycle.
- **Random duties (macro defined and undefined):** random `MotorSignal` each period → assertion: never both gates 1. Without the macro, gates are exact complements while running.
